uart_rx_core: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_rx_core.sv | 154 +++++++++++++++
 tb/tb_uart_rx_core.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART RX core, TX core and APB wrapper.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    function automatic int calc_div(input int clk, input int baud);
        return clk / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: free-running 0..DIV-1 counter, re-phased by clear_i.
module uart_baud_gen #(
    parameter int DIV = 54
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        if (clear_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 receiver with 16x oversampling and a valid/ack holding register for the APB wrapper.
module uart_rx_core #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       rx_in,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    import uart_pkg::*;

    // Only the package oversample ratio is supported, so the ratio term is 1.
    localparam int DIV = calc_div(CLK_FREQ, BAUD * (OVERSAMPLE / uart_pkg::OVERSAMPLE));

    logic       sync1_q, rxs_q;
    rx_state_t  state_q, state_d;
    logic [3:0] scnt_q, scnt_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ovr_q, ovr_d;
    logic       ferr_q;
    logic       tick, baud_clear, deliver, frame_err;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .clear_i (baud_clear),
        .tick_o  (tick)
    );

    always_comb begin
        state_d    = state_q;
        scnt_d     = scnt_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        baud_clear = 1'b0;
        deliver    = 1'b0;
        frame_err  = 1'b0;
        if ((state_q != RX_IDLE) && tick) begin
            scnt_d = scnt_q + 4'd1;
        end
        case (state_q)
            RX_IDLE: begin
                if (!rxs_q) begin
                    state_d    = RX_START;
                    scnt_d     = '0;
                    baud_clear = 1'b1;
                end
            end
            RX_START: begin
                if (tick && (scnt_q == 4'd7)) begin
                    if (!rxs_q) begin
                        state_d  = RX_DATA;
                        scnt_d   = '0;
                        bitcnt_d = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                // scnt wraps 15->0 on this tick, so STOP starts its count from zero.
                if (tick && (scnt_q == 4'd15)) begin
                    shreg_d  = {rxs_q, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick && (scnt_q == 4'd15)) begin
                    if (rxs_q) begin
                        deliver = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rxs_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // A same-cycle ack frees the holding register for the byte arriving now.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (deliver) begin
            if (!valid_q || rx_ack) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
                if (rx_ack) begin
                    ovr_d = 1'b0;
                end
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync1_q  <= 1'b1;
            rxs_q    <= 1'b1;
            state_q  <= RX_IDLE;
            scnt_q   <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            sync1_q  <= rx_in;
            rxs_q    <= sync1_q;
            state_q  <= state_d;
            scnt_q   <= scnt_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            ferr_q   <= frame_err;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
    assign rx_busy      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: serial frames in, scoreboard of expected bytes out.
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD     = 115200;
    localparam int DIV      = CLK_FREQ / (BAUD * 16);   // 54
    localparam int LAT      = 152 * DIV + 3;            // 8211 cycles fall -> rx_valid
    localparam int BIT_CYC  = 868;                      // 8680 ns per bit at 10 ns clock

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       rx_in;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_overrun, rx_busy;

    uart_rx_core #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (16)
    ) dut (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .rx_in        (rx_in),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    logic [7:0] exp_q[$];
    bit   auto_ack = 1'b0;
    int   ack_at = -1;
    int   deliveries = 0;
    int   ferr_cnt = 0;
    int   last_deliver_cyc = 0;
    int   last_fall = 0;
    logic valid_prev = 1'b0;
    logic ack_prev = 1'b0;
    bit   ev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: detects deliveries, pops the scoreboard and drives rx_ack.
    initial begin
        logic [7:0] exp_b;
        rx_ack = 1'b0;
        forever begin
            @(negedge PCLK);
            ack_prev   = rx_ack;
            ev         = rx_valid && (!valid_prev || ack_prev);
            valid_prev = rx_valid;
            if (rx_frame_err) ferr_cnt++;
            if (ev) begin
                deliveries++;
                last_deliver_cyc = cyc;
                check("sb_pending", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_b = exp_q.pop_front();
                    check("sb_data", rx_data, exp_b);
                    $display("rx byte 0x%02h at cycle %0d", rx_data, cyc);
                end
            end
            rx_ack = (cyc == ack_at) || (ev && auto_ack);
        end
    end

    // Drives one 8N1 frame starting at a negedge; optionally schedules an ack
    // ack_off cycles after the start edge, or resets the DUT mid data bit rst_bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input int ack_off, input int rst_bit);
        rx_in = 1'b0;
        last_fall = cyc;
        if (ack_off > 0) ack_at = cyc + ack_off;
        repeat (BIT_CYC) @(negedge PCLK);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            if (i == rst_bit) begin
                repeat (BIT_CYC / 2) @(negedge PCLK);
                PRESET = 1'b1;
                repeat (3) @(negedge PCLK);
                PRESET = 1'b0;
                rx_in  = 1'b1;
                return;
            end
            repeat (BIT_CYC) @(negedge PCLK);
        end
        rx_in = stop_v;
        repeat (BIT_CYC) @(negedge PCLK);
    endtask

    task automatic do_ack();
        ack_at = cyc + 1;
        repeat (3) @(negedge PCLK);
    endtask

    initial begin
        int d0, f0, lat;
        PRESET = 1'b1;
        rx_in  = 1'b1;
        repeat (3) @(negedge PCLK);
        check("rst_data",  rx_data, 8'h00);
        check("rst_valid", rx_valid, 0);
        check("rst_ferr",  rx_frame_err, 0);
        check("rst_ovr",   rx_overrun, 0);
        check("rst_busy",  rx_busy, 0);
        PRESET = 1'b0;
        repeat (5) @(negedge PCLK);

        // Single byte, latency, ack, ignored ack
        auto_ack = 1'b0;
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1, 0, -1);
        lat = last_deliver_cyc - last_fall;
        check("single_latency", (lat >= LAT - 2) && (lat <= LAT + 2), 1);
        check("single_valid", rx_valid, 1);
        check("single_data", rx_data, 8'h42);
        do_ack();
        check("single_ack_valid", rx_valid, 0);
        do_ack();
        check("idle_ack_valid", rx_valid, 0);
        check("idle_ack_data", rx_data, 8'h42);

        // Back-to-back frames, acked on delivery
        auto_ack = 1'b1;
        d0 = deliveries;
        f0 = ferr_cnt;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send_frame(8'h55, 1'b1, 0, -1);
        send_frame(8'hAA, 1'b1, 0, -1);
        repeat (10) @(negedge PCLK);
        check("b2b_count", deliveries - d0, 2);
        check("b2b_ferr", ferr_cnt - f0, 0);
        check("b2b_ovr", rx_overrun, 0);
        check("b2b_sb_empty", exp_q.size(), 0);

        // 300 ns glitch
        d0 = deliveries;
        rx_in = 1'b0;
        repeat (2) @(negedge PCLK);
        check("glitch_busy_early", rx_busy, 0);
        @(negedge PCLK);
        check("glitch_busy_rise", rx_busy, 1);
        repeat (27) @(negedge PCLK);
        rx_in = 1'b1;
        repeat (8 * DIV + 20) @(negedge PCLK);
        check("glitch_busy_end", rx_busy, 0);
        check("glitch_valid", rx_valid, 0);
        check("glitch_count", deliveries - d0, 0);

        // Framing error, break, recovery
        f0 = ferr_cnt;
        d0 = deliveries;
        send_frame(8'h3C, 1'b0, 0, -1);
        repeat (1200) @(negedge PCLK);
        check("ferr_pulses", ferr_cnt - f0, 1);
        check("ferr_break_busy", rx_busy, 1);
        check("ferr_valid", rx_valid, 0);
        rx_in = 1'b1;
        repeat (5) @(negedge PCLK);
        check("ferr_break_exit", rx_busy, 0);
        auto_ack = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 0, -1);
        check("ferr_next_data", rx_data, 8'h11);
        check("ferr_next_count", deliveries - d0, 1);
        check("ferr_total", ferr_cnt - f0, 1);

        // Delivery with coincident ack replaces the held byte
        exp_q.push_back(8'h02);
        send_frame(8'h02, 1'b1, LAT - 1, -1);
        check("coinc_data", rx_data, 8'h02);
        check("coinc_valid", rx_valid, 1);
        check("coinc_ovr", rx_overrun, 0);

        // Overrun: byte arriving while one is held is dropped
        d0 = deliveries;
        send_frame(8'h01, 1'b1, 0, -1);
        check("ovr_data", rx_data, 8'h02);
        check("ovr_flag", rx_overrun, 1);
        check("ovr_count", deliveries - d0, 0);
        do_ack();
        check("ovr_ack_valid", rx_valid, 0);
        check("ovr_ack_flag", rx_overrun, 0);

        // Reset during bit 4 of 0x99
        d0 = deliveries;
        send_frame(8'h99, 1'b1, 0, 4);
        check("mrst_data", rx_data, 8'h00);
        check("mrst_valid", rx_valid, 0);
        check("mrst_busy", rx_busy, 0);
        check("mrst_ovr", rx_overrun, 0);
        check("mrst_ferr", rx_frame_err, 0);
        repeat (5 * BIT_CYC) @(negedge PCLK);
        check("mrst_no_deliv", deliveries - d0, 0);
        exp_q.push_back(8'h99);
        send_frame(8'h99, 1'b1, 0, -1);
        repeat (10) @(negedge PCLK);
        check("mrst_next_data", rx_data, 8'h99);
        check("mrst_next_count", deliveries - d0, 1);
        check("final_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
